// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU pixel FIFO slice.
package ppu_pkg;

  localparam int unsigned PPU_ROW_PX = 8;
  // Two bitplanes give a 2-bit colour index per pixel.
  localparam int unsigned PPU_PX_W   = 2;

  typedef struct packed {
    logic [PPU_PX_W-1:0] color;
    logic                obj;
    logic                pal;
    logic                prio;
  } ppu_px_t;

  typedef enum logic {
    ST_DISCARD = 1'b0,
    ST_RUN     = 1'b1
  } PPU_FIFO_STATES_t;

endpackage

// File: rtl/ppu_row_decode.sv
// Combinational bitplane decoder: (lo,hi) tile/sprite row to 8 colour indices, leftmost first.
module ppu_row_decode
  import ppu_pkg::*;
(
  input  logic [PPU_ROW_PX-1:0]                lo,
  input  logic [PPU_ROW_PX-1:0]                hi,
  output logic [PPU_ROW_PX-1:0][PPU_PX_W-1:0] color
);

  always_comb begin
    for (int i = 0; i < PPU_ROW_PX; i++) begin
      color[i] = {hi[PPU_ROW_PX-1-i], lo[PPU_ROW_PX-1-i]};
    end
  end

endmodule

// File: rtl/ppu_pixel_fifo.sv
// Background pixel FIFO with sprite overlay and optional fine-scroll discard.
// Define PPU_FIFO_DISCARD_EN to enable the ST_DISCARD phase after flush.
module ppu_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PX_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [2:0]              fine_x,
  input  logic                    row_push,
  input  logic [7:0]              row_lo,
  input  logic [7:0]              row_hi,
  output logic                    row_ready,
  input  logic                    sp_merge,
  input  logic [7:0]              sp_lo,
  input  logic [7:0]              sp_hi,
  input  logic                    sp_pal,
  input  logic                    sp_prio,
  output logic                    sp_ack,
  input  logic                    px_ready,
  output logic                    px_valid,
  output logic [PX_W-1:0]         px_color,
  output logic                    px_obj,
  output logic                    px_pal,
  output logic                    px_prio,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  ppu_px_t                              mem [DEPTH];
  logic    [PW-1:0]                     rd_ptr;
  logic    [PW-1:0]                     wr_ptr;
  logic    [PPU_ROW_PX-1:0][PPU_PX_W-1:0] row_col;
  logic    [PPU_ROW_PX-1:0][PPU_PX_W-1:0] sp_col;
  logic                                 run;
  logic                                 drop;
  logic                                 pop;
  logic                                 push;
  logic                                 adv;
  ppu_px_t                              head;

  ppu_row_decode u_row_dec (
    .lo    (row_lo),
    .hi    (row_hi),
    .color (row_col)
  );

  ppu_row_decode u_sp_dec (
    .lo    (sp_lo),
    .hi    (sp_hi),
    .color (sp_col)
  );

  assign row_ready = (CW'(DEPTH) - count) >= CW'(PPU_ROW_PX);
  assign head      = mem[rd_ptr];
  assign px_valid  = run && (count != '0);
  assign pop       = px_valid && px_ready;
  assign push      = row_push && row_ready && !rst && !flush;
  assign sp_ack    = sp_merge && (count >= CW'(PPU_ROW_PX)) && !pop && !flush && !rst;
  assign adv       = pop || drop;

  // Head fields are forced to zero while nothing is presentable (covers post-reset).
  assign px_color = px_valid ? PX_W'(head.color) : '0;
  assign px_obj   = px_valid && head.obj;
  assign px_pal   = px_valid && head.pal;
  assign px_prio  = px_valid && head.prio;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(PPU_ROW_PX);
      end
      if (adv) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + (push ? CW'(PPU_ROW_PX) : CW'(0)) - CW'(adv);
    end
  end

  // Merge only touches the 8 entries already at the head; a same-cycle push lands
  // past them, so both write sets are disjoint.
  always_ff @(posedge clk) begin
    if (sp_ack) begin
      for (int i = 0; i < PPU_ROW_PX; i++) begin
        if ((sp_col[i] != '0) && !mem[rd_ptr + PW'(i)].obj) begin
          mem[rd_ptr + PW'(i)] <= '{color: sp_col[i], obj: 1'b1, pal: sp_pal, prio: sp_prio};
        end
      end
    end
    if (push) begin
      for (int i = 0; i < PPU_ROW_PX; i++) begin
        mem[wr_ptr + PW'(i)] <= '{color: row_col[i], obj: 1'b0, pal: 1'b0, prio: 1'b0};
      end
    end
  end

`ifdef PPU_FIFO_DISCARD_EN
  PPU_FIFO_STATES_t state;
  logic [2:0]       disc_cnt;

  assign run  = (state == ST_RUN);
  assign drop = !run && (count != '0) && (disc_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      disc_cnt <= '0;
    end else if (flush) begin
      disc_cnt <= fine_x;
      state    <= (fine_x == '0) ? ST_RUN : ST_DISCARD;
    end else if (!run) begin
      if (drop) begin
        disc_cnt <= disc_cnt - 3'd1;
        // Leave as the last pixel is dropped so output starts on the next cycle.
        if (disc_cnt == 3'd1) begin
          state <= ST_RUN;
        end
      end else if (disc_cnt == '0) begin
        state <= ST_RUN;
      end
    end
  end
`else
  logic unused_fine_x;
  assign unused_fine_x = ^fine_x;
  assign run           = 1'b1;
  assign drop          = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Self-checking bench for ppu_pixel_fifo against a queue-based pixel model.
module tb_ppu_pixel_fifo;

  localparam int DEPTH = 16;
  localparam int PX_W  = 2;
`ifdef PPU_FIFO_DISCARD_EN
  localparam bit DISC_EN = 1'b1;
`else
  localparam bit DISC_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [2:0]      fine_x;
  logic            row_push;
  logic [7:0]      row_lo;
  logic [7:0]      row_hi;
  logic            row_ready;
  logic            sp_merge;
  logic [7:0]      sp_lo;
  logic [7:0]      sp_hi;
  logic            sp_pal;
  logic            sp_prio;
  logic            sp_ack;
  logic            px_ready;
  logic            px_valid;
  logic [PX_W-1:0] px_color;
  logic            px_obj;
  logic            px_pal;
  logic            px_prio;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  ppu_pixel_fifo #(
    .DEPTH (DEPTH),
    .PX_W  (PX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fine_x    (fine_x),
    .row_push  (row_push),
    .row_lo    (row_lo),
    .row_hi    (row_hi),
    .row_ready (row_ready),
    .sp_merge  (sp_merge),
    .sp_lo     (sp_lo),
    .sp_hi     (sp_hi),
    .sp_pal    (sp_pal),
    .sp_prio   (sp_prio),
    .sp_ack    (sp_ack),
    .px_ready  (px_ready),
    .px_valid  (px_valid),
    .px_color  (px_color),
    .px_obj    (px_obj),
    .px_pal    (px_pal),
    .px_prio   (px_prio),
    .count     (count)
  );

  typedef struct {
    logic [1:0] color;
    logic       obj;
    logic       pal;
    logic       prio;
  } mpx_t;

  mpx_t q[$];
  int   mdisc;
  int   n_checks;
  int   n_fail;

  function automatic bit m_valid();
    return (mdisc == 0) && (q.size() > 0);
  endfunction

  function automatic bit m_ready();
    return q.size() <= DEPTH - 8;
  endfunction

  function automatic bit m_ack();
    return !rst && !flush && sp_merge && (q.size() >= 8) && !(m_valid() && px_ready);
  endfunction

  // Advance the model by the current inputs, then clock the DUT.
  task automatic tick();
    bit   pop, drop, push, merge;
    mpx_t e;
    logic [1:0] c;
    pop   = m_valid() && px_ready;
    drop  = (mdisc > 0) && (q.size() > 0);
    push  = row_push && m_ready();
    merge = m_ack();
    if (rst) begin
      q.delete();
      mdisc = 0;
    end else if (flush) begin
      q.delete();
      mdisc = DISC_EN ? int'(fine_x) : 0;
    end else begin
      if (merge) begin
        for (int i = 0; i < 8; i++) begin
          c = {sp_hi[7-i], sp_lo[7-i]};
          e = q[i];
          if (c != 2'd0 && !e.obj) begin
            e.color = c; e.obj = 1'b1; e.pal = sp_pal; e.prio = sp_prio;
            q[i] = e;
          end
        end
      end
      if (pop || drop) begin
        void'(q.pop_front());
        if (drop) mdisc--;
      end
      if (push) begin
        for (int i = 0; i < 8; i++) begin
          e.color = {row_hi[7-i], row_lo[7-i]}; e.obj = 1'b0; e.pal = 1'b0; e.prio = 1'b0;
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; fine_x = 3'd0; row_push = 1'b0; row_lo = 8'h00; row_hi = 8'h00;
    sp_merge = 1'b0; sp_lo = 8'h00; sp_hi = 8'h00; sp_pal = 1'b0; sp_prio = 1'b0;
    px_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    row_push = 1'b1; row_lo = 8'hA5; row_hi = 8'h3C;
    tick();
    rst = 1'b1; flush = 1'b1; fine_x = 3'd5; sp_merge = 1'b1; sp_lo = 8'hFF;
    tick();
    idle_inputs();
    sp_merge = 1'b1; sp_lo = 8'hFF;
    #1;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (px_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", px_valid); end
    n_checks++; if (row_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", row_ready); end
    n_checks++; if (sp_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", sp_ack); end
    n_checks++;
    if ({px_color, px_obj, px_pal, px_prio} !== 5'd0) begin
      n_fail++; $display("FAIL reset_px got %b want 00000", {px_color, px_obj, px_pal, px_prio});
    end
    // First push after reset must not discard, whatever fine_x was during reset.
    sp_merge = 1'b0; row_push = 1'b1; row_lo = 8'hFF;
    tick();
    row_push = 1'b0;
    n_checks++; if (px_valid !== 1'b1) begin n_fail++; $display("FAIL reset_run got %b want 1", px_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_decode();
    int exp_c [8] = '{3, 3, 1, 1, 2, 2, 0, 0};
    idle_inputs();
    row_push = 1'b1; row_lo = 8'hF0; row_hi = 8'hCC;
    tick();
    row_push = 1'b0;
    n_checks++; if (count !== 5'd8) begin n_fail++; $display("FAIL decode_count got %0d want 8", count); end
    px_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (px_valid !== 1'b1 || px_color !== 2'(exp_c[i])) begin
        n_fail++; $display("FAIL decode_px%0d got v=%b c=%0d want v=1 c=%0d", i, px_valid, px_color,
                           exp_c[i]);
      end
      tick();
    end
    px_ready = 1'b0;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL decode_drain got %0d want 0", count); end
  endtask

  task automatic test_full();
    idle_inputs();
    for (int r = 0; r < 3; r++) begin
      row_push = 1'b1; row_lo = 8'($urandom); row_hi = 8'($urandom);
      tick();
    end
    row_push = 1'b0;
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", count); end
    n_checks++; if (row_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", row_ready); end
    px_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (px_color !== q[0].color) begin
        n_fail++; $display("FAIL full_data%0d got %0d want %0d", i, px_color, q[0].color);
      end
      tick();
    end
    px_ready = 1'b0;
  endtask

  task automatic test_merge();
    for (int pass = 0; pass < 2; pass++) begin
      idle_inputs();
      row_push = 1'b1;
      tick();
      row_push = 1'b0;
      sp_merge = 1'b1; sp_lo = 8'h80; sp_hi = 8'h00; sp_pal = 1'b1;
      #1;
      n_checks++; if (sp_ack !== 1'b1) begin n_fail++; $display("FAIL merge1_ack got %b want 1", sp_ack); end
      tick();
      if (pass == 1) begin
        sp_lo = 8'hFF; sp_hi = 8'hFF; sp_pal = 1'b0; sp_prio = 1'b1;
        #1;
        n_checks++; if (sp_ack !== 1'b1) begin n_fail++; $display("FAIL merge2_ack got %b want 1", sp_ack); end
        tick();
      end
      sp_merge = 1'b0;
      px_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
        logic [4:0] want;
        if (i == 0) want = {2'd1, 1'b1, 1'b1, 1'b0};
        else if (pass == 1) want = {2'd3, 1'b1, 1'b0, 1'b1};
        else want = 5'd0;
        n_checks++;
        if ({px_color, px_obj, px_pal, px_prio} !== want) begin
          n_fail++; $display("FAIL merge_p%0d_px%0d got %b want %b", pass, i,
                             {px_color, px_obj, px_pal, px_prio}, want);
        end
        tick();
      end
      px_ready = 1'b0;
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    for (int r = 0; r < 5; r++) begin
      logic [7:0] lo, hi;
      lo = 8'($urandom); hi = 8'($urandom);
      row_push = 1'b1; row_lo = lo; row_hi = hi;
      tick();
      row_push = 1'b0; px_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (px_valid !== 1'b1 || px_color !== {hi[7-i], lo[7-i]}) begin
          n_fail++; $display("FAIL wrap_r%0d_px%0d got v=%b c=%0d want v=1 c=%0d", r, i, px_valid,
                             px_color, {hi[7-i], lo[7-i]});
        end
        tick();
      end
      px_ready = 1'b0;
    end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL wrap_count got %0d want 0", count); end
  endtask

  task automatic test_discard();
    int waits, outs, exp_disc;
    idle_inputs();
    row_push = 1'b1; row_lo = 8'h0F;
    tick();
    flush = 1'b1; fine_x = 3'd3;
    tick();
    flush = 1'b0; row_push = 1'b1; row_lo = 8'hFF; row_hi = 8'h00;
    tick();
    row_push = 1'b0; px_ready = 1'b1;
    exp_disc = DISC_EN ? 3 : 0;
    waits = 0; outs = 0;
    for (int c = 0; c < 40; c++) begin
      if (px_valid) begin
        outs++;
        n_checks++;
        if (px_color !== 2'd1) begin n_fail++; $display("FAIL disc_color got %0d want 1", px_color); end
      end else if (outs == 0) begin
        waits++;
      end
      tick();
    end
    px_ready = 1'b0;
    n_checks++; if (waits != exp_disc) begin n_fail++; $display("FAIL disc_wait got %0d want %0d", waits, exp_disc); end
    n_checks++; if (outs != 8 - exp_disc) begin n_fail++; $display("FAIL disc_outs got %0d want %0d", outs, 8 - exp_disc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 29) == 0);
      fine_x   = 3'($urandom);
      row_push = ($urandom_range(0, 2) == 0);
      row_lo   = 8'($urandom); row_hi = 8'($urandom);
      sp_merge = ($urandom_range(0, 3) == 0);
      sp_lo    = 8'($urandom); sp_hi = 8'($urandom);
      sp_pal   = 1'($urandom); sp_prio = 1'($urandom);
      px_ready = 1'($urandom);
      #1;
      n_checks++;
      if (sp_ack !== m_ack()) begin n_fail++; $display("FAIL rnd_ack c%0d got %b want %b", c, sp_ack, m_ack()); end
      n_checks++;
      if (count !== 5'(q.size())) begin
        n_fail++; $display("FAIL rnd_count c%0d got %0d want %0d", c, count, q.size());
      end
      n_checks++;
      if (row_ready !== m_ready()) begin
        n_fail++; $display("FAIL rnd_ready c%0d got %b want %b", c, row_ready, m_ready());
      end
      n_checks++;
      if (px_valid !== m_valid()) begin
        n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", c, px_valid, m_valid());
      end else if (m_valid()) begin
        n_checks++;
        if ({px_color, px_obj, px_pal, px_prio} !== {q[0].color, q[0].obj, q[0].pal, q[0].prio}) begin
          n_fail++; $display("FAIL rnd_px c%0d got %b want %b", c, {px_color, px_obj, px_pal, px_prio},
                             {q[0].color, q[0].obj, q[0].pal, q[0].prio});
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; mdisc = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_decode();
    test_full();
    test_merge();
    test_wrap();
    test_discard();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_pixel_fifo.md
PPU_PIXEL_FIFO -- requirements
Module: ppu_pixel_fifo

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 16, entry count; power of two, >=16.
- PX_W, default 2, colour-index width.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  empty FIFO, start new scanline.
- fine_x  in  3  pixels to discard after flush (SCX%8).
- row_push  in  1  push 8-pixel tile row.
- row_lo  in  8  bitplane 0, bit7 leftmost.
- row_hi  in  8  bitplane 1, bit7 leftmost.
- row_ready  out  1  free entries >=8.
- sp_merge  in  1  overlay sprite row.
- sp_lo  in  8  sprite plane 0.
- sp_hi  in  8  sprite plane 1.
- sp_pal  in  1  OBP select.
- sp_prio  in  1  behind-BG flag.
- sp_ack  out  1  merge accepted this cycle.
- px_ready  in  1  consumer takes pixel.
- px_valid  out  1  head pixel available.
- px_color  out  PX_W  head colour.
- px_obj  out  1  head is sprite.
- px_pal  out  1  head palette.
- px_prio  out  1  head priority.
- count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-003 Each entry SHALL hold {color[PX_W-1:0], obj, pal, prio}.
REQ-004 Storage SHALL be a circular buffer, with rd_ptr/wr_ptr wrapping modulo DEPTH.
REQ-005 row_push with row_ready=1 SHALL write 8 entries at wr_ptr..wr_ptr+7 with color={row_hi[7-i],row_lo[7-i]}, obj=0, pal=0, prio=0.
REQ-006 row_push with row_ready=0 SHALL be ignored, with no state change.
REQ-007 A pop SHALL occur when px_valid&&px_ready; it advances rd_ptr by 1 and decrements count.
REQ-008 Simultaneous push and pop SHALL yield count+7.
REQ-009 row_ready SHALL be computed from the registered count at cycle start.
REQ-010 sp_ack SHALL equal sp_merge && count>=8 && !(px_valid&&px_ready) && !flush; merge otherwise ignored.
REQ-011 On accepted merge, entry rd_ptr+i (i=0..7) SHALL take {sprite colour, obj=1, sp_pal, sp_prio} only if sprite colour {sp_hi[7-i],sp_lo[7-i]}!=0 and entry obj==0; first-written sprite wins.
REQ-012 Merge and push in the same cycle SHALL both apply; merge affects only entries present before the push.
REQ-013 FSM states SHALL be ST_DISCARD and ST_RUN.
REQ-014 In ST_DISCARD:
- px_valid SHALL be 0.
- When count>0 and disc_cnt>0, one entry SHALL be dropped per cycle, decrementing disc_cnt.
- When disc_cnt==0, the FSM SHALL go to ST_RUN.
REQ-015 In ST_RUN, px_valid SHALL be (count>0), and the px_* outputs SHALL be combinational from the rd_ptr entry.
REQ-016 flush SHALL take priority over push, merge and pop in its cycle:
- count=0, pointers=0.
- disc_cnt<=fine_x.
- state<=ST_DISCARD, or ST_RUN if fine_x==0.
REQ-017 Pop, push and merge SHALL have zero-cycle acceptance latency; pushed pixels SHALL be visible on px_* the cycle after the push.

Reset
REQ-018 rst SHALL set count=0, rd_ptr=wr_ptr=0, disc_cnt=0, state=ST_RUN; hence px_valid=0, row_ready=1, sp_ack=0, and px_color/px_obj/px_pal/px_prio=0.
REQ-019 rst SHALL override flush, push and merge in the same cycle; entry contents need not be cleared.

Configuration
REQ-020 The macro PPU_FIFO_DISCARD_EN SHALL gate fine-scroll discard.
REQ-021 With PPU_FIFO_DISCARD_EN defined, behaviour SHALL be per REQ-014 and REQ-016.
REQ-022 Without PPU_FIFO_DISCARD_EN, fine_x SHALL be ignored, ST_DISCARD SHALL be absent, and flush SHALL always enter ST_RUN.

Structure
REQ-023 Package ppu_pkg SHALL hold:
- typedef ppu_px_t {color, obj, pal, prio};
- enum PPU_FIFO_STATES_t {ST_DISCARD, ST_RUN};
- constant PPU_ROW_PX=8.
REQ-024 Sub-module ppu_row_decode SHALL be combinational; it converts (lo,hi) to 8 colour indices and is shared by the push and merge paths.

Verification
REQ-025 Push row_lo=8'hF0, row_hi=8'hCC, then pop 8 -> colours 3,3,1,1,2,2,0,0.
REQ-026 DEPTH=16, push twice, no pop -> count=16, row_ready=0; third push ignored, count stays 16.
REQ-027 Push row_lo=row_hi=8'h00; merge sp_lo=8'h80, sp_hi=8'h00, sp_pal=1 -> sp_ack=1; first pop color=1, obj=1, pal=1; remaining seven pops obj=0.
REQ-028 Second merge with sp_lo=sp_hi=8'hFF after REQ-027 -> entry0 unchanged (color=1, pal=1); entries1-7 color=3, obj=1.
REQ-029 With PPU_FIFO_DISCARD_EN: flush, fine_x=3, push 8'hFF/8'h00 -> px_valid rises after 3 drop cycles; 5 pixels out, color=1.
REQ-030 Pointer wrap over 5 push/pop-8 cycles with DEPTH=16 -> data order preserved; count returns 0.
